// File: rtl/intersection_responder.sv
// Intersection-side responder: per-direction car queues, one-at-a-time release under the
// current light commands, box occupancy timing and sticky illegal-light detection.
module intersection_responder #(
  parameter int QDEPTH       = 4,
  parameter int CROSS_CYCLES = 8,
  parameter int DROP_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        lightN,
  input  logic [2:0]        lightS,
  input  logic [2:0]        lightE,
  input  logic [2:0]        lightW,
  input  logic [3:0]        arrive,
  input  logic [7:0]        arrive_turn,
  output logic [3:0]        depart,
  output logic [1:0]        depart_turn,
  output logic              occupied,
  output logic [3:0]        queue_full,
  output logic [7:0]        sensor_light,
  output logic              fault,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int TW = (CROSS_CYCLES > 1) ? $clog2(CROSS_CYCLES) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);
  localparam logic [TW-1:0] TLOAD    = TW'(CROSS_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CROSS,
    ST_FAULT
  } state_e;

  logic [1:0]        mem_q   [4][QDEPTH];
  logic [PW-1:0]     wrPtr_q [4];
  logic [PW-1:0]     rdPtr_q [4];
  logic [CW-1:0]     cnt_q   [4];
  logic [DROP_W-1:0] dropCnt_q, dropCnt_d;

  state_e            state_q;
  logic [TW-1:0]     timer_q;
  logic [1:0]        rr_q;
  logic [1:0]        src_q;
  logic [3:0]        depart_q;
  logic [1:0]        departTurn_q;
  logic              fault_q;

  logic [2:0] light    [4];
  logic [1:0] head     [4];
  logic [1:0] normTurn [4];
  logic [3:0] nonEmpty, full, eligible, nonStop, push, drop, pop;
  logic       badCode, violation, grantValid, doGrant;
  logic [1:0] grantDir, idx;
  logic [2:0] dropSum;
  logic [DROP_W:0] dropExt;

  assign light[0] = lightN;
  assign light[1] = lightS;
  assign light[2] = lightE;
  assign light[3] = lightW;

  // Per-direction queue status, head-of-queue eligibility and light legality.
  always_comb begin
    badCode = 1'b0;
    for (int d = 0; d < 4; d++) begin
      head[d]     = mem_q[d][rdPtr_q[d]];
      nonEmpty[d] = (cnt_q[d] != '0);
      full[d]     = (cnt_q[d] == FULL_CNT);
      nonStop[d]  = (light[d] != 3'b000);
      badCode     = badCode | (light[d] > 3'd4);
      eligible[d] = nonEmpty[d] &
                    ((light[d] == 3'b100) |
                     ((light[d] == 3'b001) & (head[d] == 2'b00)) |
                     ((light[d] == 3'b010) & (head[d] == 2'b01)) |
                     ((light[d] == 3'b011) & (head[d] == 2'b10)));
      normTurn[d] = (arrive_turn[2*d +: 2] == 2'b11) ? 2'b00 : arrive_turn[2*d +: 2];
    end
    violation = badCode | ((nonStop & (nonStop - 4'd1)) != 4'd0);
  end

  // Round-robin search begins just after the last served direction, so it is checked last.
  always_comb begin
    grantValid = 1'b0;
    grantDir   = rr_q;
    idx        = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = rr_q + 2'(i);
      if (!grantValid && eligible[idx]) begin
        grantValid = 1'b1;
        grantDir   = idx;
      end
    end
    doGrant = (state_q == ST_IDLE) && !fault_q && !violation && grantValid;
    pop     = doGrant ? (4'b0001 << grantDir) : 4'b0000;
  end

  // A full queue rejects arrivals even when it pops in the same cycle.
  always_comb begin
    push      = arrive & ~full;
    drop      = arrive & full;
    dropSum   = 3'(drop[0]) + 3'(drop[1]) + 3'(drop[2]) + 3'(drop[3]);
    dropExt   = {1'b0, dropCnt_q} + (DROP_W + 1)'(dropSum);
    dropCnt_d = dropExt[DROP_W] ? {DROP_W{1'b1}} : dropExt[DROP_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < 4; d++) begin
        wrPtr_q[d] <= '0;
        rdPtr_q[d] <= '0;
        cnt_q[d]   <= '0;
        for (int e = 0; e < QDEPTH; e++) mem_q[d][e] <= 2'b00;
      end
      dropCnt_q <= '0;
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (push[d]) begin
          mem_q[d][wrPtr_q[d]] <= normTurn[d];
          wrPtr_q[d]           <= wrPtr_q[d] + PW'(1);
        end
        if (pop[d]) rdPtr_q[d] <= rdPtr_q[d] + PW'(1);
        cnt_q[d] <= cnt_q[d] + CW'(push[d]) - CW'(pop[d]);
      end
      dropCnt_q <= dropCnt_d;
    end
  end

  // A crossing already in progress always completes before the fault state takes over.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      rr_q         <= 2'd0;
      src_q        <= 2'd0;
      depart_q     <= 4'b0000;
      departTurn_q <= 2'b00;
      fault_q      <= 1'b0;
    end else begin
      depart_q <= 4'b0000;
      fault_q  <= fault_q | violation;
      case (state_q)
        ST_IDLE: begin
          if (fault_q || violation) begin
            state_q <= ST_FAULT;
          end else if (grantValid) begin
            depart_q     <= pop;
            departTurn_q <= head[grantDir];
            timer_q      <= TLOAD;
            rr_q         <= grantDir;
            src_q        <= grantDir;
            state_q      <= ST_CROSS;
          end
        end
        ST_CROSS: begin
          if (timer_q == '0) state_q <= (fault_q || violation) ? ST_FAULT : ST_IDLE;
          else timer_q <= timer_q - TW'(1);
        end
        default: state_q <= ST_FAULT;
      endcase
    end
  end

  assign depart       = depart_q;
  assign depart_turn  = departTurn_q;
  assign occupied     = (state_q == ST_CROSS);
  assign queue_full   = full;
  assign sensor_light = {(occupied ? (4'b0001 << src_q) : 4'b0000), nonEmpty};
  assign fault        = fault_q;
  assign drop_cnt     = dropCnt_q;

endmodule

// File: tb/tb_intersection_responder.sv
// Scoreboard bench for intersection_responder: expected departures are queued as cars are
// driven in and matched against depart/depart_turn whenever a departure pulse appears.
module tb_intersection_responder;

  localparam int CC = 8;
  localparam logic [2:0] STOP = 3'b000;
  localparam logic [2:0] GO   = 3'b100;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] lightN, lightS, lightE, lightW;
  logic [3:0] arrive;
  logic [7:0] arrive_turn;
  logic [3:0] depart;
  logic [1:0] depart_turn;
  logic       occupied;
  logic [3:0] queue_full;
  logic [7:0] sensor_light;
  logic       fault;
  logic [7:0] drop_cnt;

  typedef struct packed {
    logic [3:0] dep;
    logic [1:0] turn;
  } exp_t;

  exp_t sbq[$];
  exp_t expE;
  int   checks = 0;
  int   errors = 0;

  intersection_responder #(.QDEPTH(4), .CROSS_CYCLES(CC), .DROP_W(8)) dut (
    .clk(clk), .rst(rst),
    .lightN(lightN), .lightS(lightS), .lightE(lightE), .lightW(lightW),
    .arrive(arrive), .arrive_turn(arrive_turn),
    .depart(depart), .depart_turn(depart_turn), .occupied(occupied),
    .queue_full(queue_full), .sensor_light(sensor_light), .fault(fault), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Every departure pulse must be one-hot and match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && depart !== 4'b0000) begin
      checks++;
      if (!$onehot(depart)) begin
        errors++;
        $display("[TB] FAIL depart_onehot: got %b, expected a one-hot value", depart);
      end
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("[TB] FAIL depart_unexpected: got depart=%b turn=%b, expected no departure",
                 depart, depart_turn);
      end else begin
        expE = sbq.pop_front();
        if (depart !== expE.dep || depart_turn !== expE.turn) begin
          errors++;
          $display("[TB] FAIL depart_match: got depart=%b turn=%b, expected depart=%b turn=%b",
                   depart, depart_turn, expE.dep, expE.turn);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic setLights(input logic [2:0] n, input logic [2:0] s,
                           input logic [2:0] e, input logic [2:0] w);
    lightN = n; lightS = s; lightE = e; lightW = w;
  endtask

  task automatic doReset;
    @(negedge clk);
    rst = 1'b0;
    setLights(STOP, STOP, STOP, STOP);
    arrive = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    checks++;
    if ({depart, depart_turn, occupied, fault} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got depart=%b turn=%b occ=%b fault=%b, expected all 0",
               depart, depart_turn, occupied, fault);
    end
    checks++;
    if ({queue_full, sensor_light, drop_cnt} !== 20'h0) begin
      errors++;
      $display("[TB] FAIL reset_status: got full=%b sensor=%b drop=%0d, expected all 0",
               queue_full, sensor_light, drop_cnt);
    end
  endtask

  task automatic test_reset_mid_cross;
    int n;
    sbq.push_back({4'b0001, 2'b10});
    lightN = GO;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      arrive      = 4'b0001;
      arrive_turn = {6'b0, (c == 0) ? 2'b10 : (c == 1) ? 2'b01 : 2'b00};
    end
    @(negedge clk);
    arrive = 4'b0000;
    checks++;
    if (occupied !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_cross_occupied: got %b, expected 1", occupied);
    end
    #2 rst = 1'b0;
    #1 test_reset;
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (depart !== 4'b0000) n++;
    end
    checks++;
    if (n != 0 || sensor_light !== 8'h00) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got departs=%0d sensor=%b, expected 0 and 00000000",
               n, sensor_light);
    end
    lightN = STOP;
  endtask

  task automatic test_go_sequence;
    int t[3];
    int k;
    k = 0;
    sbq.push_back({4'b0001, 2'b00});
    sbq.push_back({4'b0001, 2'b01});
    sbq.push_back({4'b0001, 2'b10});
    lightN = GO;
    for (int c = 0; c < 60 && k < 3; c++) begin
      @(negedge clk);
      if (depart[0] === 1'b1) begin
        if (k < 3) t[k] = c;
        k++;
      end
      arrive      = (c < 3) ? 4'b0001 : 4'b0000;
      arrive_turn = {6'b0, (c == 0) ? 2'b00 : (c == 1) ? 2'b01 : 2'b10};
    end
    checks++;
    if (k != 3 || t[0] != 2) begin
      errors++;
      $display("[TB] FAIL go_count: got %0d departs first at %0d, expected 3 first at 2", k, t[0]);
    end
    checks++;
    if (t[1] - t[0] != CC + 1 || t[2] - t[1] != CC + 1) begin
      errors++;
      $display("[TB] FAIL go_spacing: got %0d/%0d, expected %0d", t[1] - t[0], t[2] - t[1], CC + 1);
    end
    checks++;
    if (sensor_light[0] !== 1'b0 || sensor_light[4] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL go_sensor: got %b, expected bit0=0 bit4=1", sensor_light);
    end
    repeat (CC + 2) @(negedge clk);
    lightN = STOP;
    checks++;
    if (occupied !== 1'b0) begin
      errors++;
      $display("[TB] FAIL go_cross_end: got occupied=%b, expected 0", occupied);
    end
  endtask

  task automatic test_left_only;
    int n;
    lightE = 3'b010;
    @(negedge clk);
    arrive = 4'b0100; arrive_turn = 8'h00;
    @(negedge clk);
    arrive_turn = 8'b0001_0000;
    @(negedge clk);
    arrive = 4'b0000;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (depart !== 4'b0000) n++;
    end
    checks++;
    if (n != 0 || sensor_light[2] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL left_block: got departs=%0d sensor=%b, expected 0 and bit2=1", n, sensor_light);
    end
    sbq.push_back({4'b0100, 2'b00});
    sbq.push_back({4'b0100, 2'b01});
    lightE = GO;
    n = 0;
    for (int c = 0; c < 40 && n < 2; c++) begin
      @(negedge clk);
      if (depart[2] === 1'b1) begin
        n++;
        lightE = 3'b010;
      end
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("[TB] FAIL left_release: got %0d departs, expected 2", n);
    end
    lightE = STOP;
    repeat (CC + 2) @(negedge clk);
  endtask

  task automatic test_full_drop;
    int n;
    logic [1:0] tv;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tv = (c == 0) ? 2'b11 : (c == 1) ? 2'b10 : (c == 2) ? 2'b01 :
           (c == 3) ? 2'b00 : (c == 4) ? 2'b10 : 2'b01;
      arrive      = 4'b1000;
      arrive_turn = {tv, 6'b0};
      if (c < 4) sbq.push_back({4'b1000, (tv == 2'b11) ? 2'b00 : tv});
    end
    @(negedge clk);
    arrive = 4'b0000;
    checks++;
    if (queue_full !== 4'b1000 || drop_cnt !== 8'd2) begin
      errors++;
      $display("[TB] FAIL full_drop: got full=%b drop=%0d, expected 1000 and 2", queue_full, drop_cnt);
    end
    lightW      = GO;
    arrive      = 4'b1000;
    arrive_turn = 8'b0100_0000;
    @(negedge clk);
    arrive = 4'b0000;
    n = (depart[3] === 1'b1) ? 1 : 0;
    checks++;
    if (drop_cnt !== 8'd3 || n != 1) begin
      errors++;
      $display("[TB] FAIL pushpop_full: got drop=%0d depart=%b, expected 3 and 1000", drop_cnt, depart);
    end
    for (int c = 0; c < 80 && n < 4; c++) begin
      @(negedge clk);
      if (depart[3] === 1'b1) n++;
    end
    checks++;
    if (n != 4 || queue_full !== 4'b0000 || sensor_light[3] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_drain: got departs=%0d full=%b sensor=%b, expected 4 0000 bit3=0",
               n, queue_full, sensor_light);
    end
    lightW = STOP;
    repeat (CC + 2) @(negedge clk);
  endtask

  task automatic test_round_robin;
    int n;
    @(negedge clk);
    arrive = 4'b0101; arrive_turn = 8'h00;
    @(negedge clk);
    @(negedge clk);
    arrive = 4'b0000;
    sbq.push_back({4'b0001, 2'b00});
    sbq.push_back({4'b0100, 2'b00});
    sbq.push_back({4'b0001, 2'b00});
    sbq.push_back({4'b0100, 2'b00});
    lightN = GO;
    n = 0;
    for (int c = 0; c < 100 && n < 4; c++) begin
      @(negedge clk);
      if (depart !== 4'b0000) begin
        n++;
        if (depart[0] === 1'b1) setLights(STOP, STOP, GO, STOP);
        else setLights(GO, STOP, STOP, STOP);
      end
    end
    checks++;
    if (n != 4 || sensor_light[3:0] !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL rr_alternate: got departs=%0d sensor=%b, expected 4 and low nibble 0",
               n, sensor_light);
    end
    setLights(STOP, STOP, STOP, STOP);
    repeat (CC + 2) @(negedge clk);
  endtask

  task automatic test_fault;
    int n;
    int occ;
    bit seen;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      arrive = 4'b0001; arrive_turn = 8'h00;
    end
    @(negedge clk);
    arrive = 4'b0000;
    sbq.push_back({4'b0001, 2'b00});
    lightN = GO;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (occupied === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL fault_grant: got occupied=%b, expected 1 within 20 cycles", occupied);
    end
    occ    = 1;
    lightS = GO;
    @(negedge clk);
    lightS = STOP;
    if (occupied === 1'b1) occ++;
    checks++;
    if (fault !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fault_raise: got fault=%b, expected 1", fault);
    end
    for (int c = 0; c < 20 && occupied === 1'b1; c++) begin
      @(negedge clk);
      if (occupied === 1'b1) occ++;
    end
    checks++;
    if (occ != CC) begin
      errors++;
      $display("[TB] FAIL fault_cross_len: got %0d cycles, expected %0d", occ, CC);
    end
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (depart !== 4'b0000) n++;
    end
    checks++;
    if (n != 0 || fault !== 1'b1 || sensor_light[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fault_hold: got departs=%0d fault=%b sensor=%b, expected 0 1 bit0=1",
               n, fault, sensor_light);
    end
    @(negedge clk);
    arrive = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    arrive = 4'b0000;
    checks++;
    if (queue_full[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fault_arrivals: got full=%b, expected bit0=1", queue_full);
    end
    doReset;
    @(negedge clk);
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fault_clear: got fault=%b, expected 0", fault);
    end
    lightW = 3'b110;
    @(negedge clk);
    lightW = STOP;
    checks++;
    if (fault !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fault_badcode: got fault=%b, expected 1", fault);
    end
  endtask

  initial begin
    rst         = 1'b0;
    setLights(STOP, STOP, STOP, STOP);
    arrive      = 4'b0000;
    arrive_turn = 8'h00;
    #3 test_reset;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    test_reset_mid_cross;
    test_go_sequence;
    test_left_only;
    test_full_drop;
    test_round_robin;
    test_fault;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d outstanding, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
